// File: rtl/fir_out_sink.sv
// rtl/fir_out_sink.sv - FIR output capture with runtime decimation and FWFT buffering
module fir_out_sink #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int DECIM_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        fir_data,
    input  logic                     fir_ready,
    input  logic [DECIM_W-1:0]       decim,
    input  logic                     clear,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        LVL_ZERO  = '0;
    localparam logic [AW:0]        LVL_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]        LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]      PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DECIM_W-1:0] DECIM_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]        level_q, level_nxt;
    logic [DECIM_W-1:0] dcnt, dcnt_nxt;
    logic [DATA_W-1:0]  head_q, head_nxt;
    logic               keep, pop, push, drop, full;

    always_comb begin
        full = (level_q == LVL_FULL);
        keep = fir_ready && (dcnt == '0);
        pop  = (level_q != LVL_ZERO) && m_ready && !clear;
        push = keep && !clear && (!full || pop);
        drop = keep && !clear && full && !pop;

        dcnt_nxt = dcnt;
        if (clear) begin
            dcnt_nxt = '0;
        end else if (fir_ready) begin
            // A factor lowered below the running count wraps immediately rather than sticking.
            if (decim <= DECIM_ONE || dcnt >= decim - DECIM_ONE)
                dcnt_nxt = '0;
            else
                dcnt_nxt = dcnt + DECIM_ONE;
        end

        level_nxt = level_q;
        if (clear)
            level_nxt = LVL_ZERO;
        else if (push && !pop)
            level_nxt = level_q + LVL_ONE;
        else if (pop && !push)
            level_nxt = level_q - LVL_ONE;

        rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;

        // Head is registered so it holds its last value when the FIFO drains.
        head_nxt = head_q;
        if (!clear) begin
            if (push && (level_q == LVL_ZERO || (level_q == LVL_ONE && pop)))
                head_nxt = fir_data;
            else if (level_nxt != LVL_ZERO)
                head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= fir_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            head_q   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            dcnt     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            dcnt    <= dcnt_nxt;
            level_q <= level_nxt;
            rd_ptr  <= rd_ptr_nxt;
            head_q  <= head_nxt;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign m_data  = head_q;
    assign m_valid = (level_q != LVL_ZERO);
    assign level   = level_q;
endmodule

// File: tb/tb_fir_out_sink.sv
// tb/tb_fir_out_sink.sv - self-checking bench for fir_out_sink
module tb_fir_out_sink;
    logic        clk = 0;
    logic        rst = 1;
    logic [15:0] fir_data = '0;
    logic        fir_ready = 0;
    logic [7:0]  decim = 8'd1;
    logic        clear = 0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 0;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    int          mdcnt = 0;
    logic        movf = 0;
    int          mdrops = 0;
    int          pops = 0;
    logic [15:0] last_pop = '0;

    fir_out_sink #(.DATA_W(16), .DEPTH(8), .DECIM_W(8)) dut (
        .clk(clk), .rst(rst), .fir_data(fir_data), .fir_ready(fir_ready),
        .decim(decim), .clear(clear), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: state observed at each negedge, then the upcoming edge's push/pop applied.
    always @(negedge clk) begin
        logic [3:0] exp_lvl;
        logic       full_before, mpop, kept;
        if (rst) begin
            q.delete();
            mdcnt = 0; movf = 0; mdrops = 0;
        end else begin
            exp_lvl = 4'(q.size());
            checks++;
            if (level !== exp_lvl) begin
                errors++; $display("FAIL sb_level: got %0d expected %0d", level, exp_lvl);
            end
            checks++;
            if (m_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL sb_valid: got %0b expected %0b", m_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (m_data !== q[0]) begin
                    errors++; $display("FAIL sb_data: got %0h expected %0h", m_data, q[0]);
                end
            end
            checks++;
            if (overflow !== movf || drop_cnt !== 16'(mdrops)) begin
                errors++;
                $display("FAIL sb_ovf: got ovf=%0b drops=%0d expected ovf=%0b drops=%0d",
                         overflow, drop_cnt, movf, mdrops);
            end
            if (clear) begin
                q.delete();
                mdcnt = 0; movf = 0; mdrops = 0;
            end else begin
                full_before = (q.size() == 8);
                mpop = (q.size() != 0) && m_ready;
                if (mpop) begin
                    last_pop = q.pop_front();
                    pops++;
                end
                if (fir_ready) begin
                    kept = (mdcnt == 0);
                    if (decim <= 1 || mdcnt >= int'(decim) - 1) mdcnt = 0;
                    else mdcnt = mdcnt + 1;
                    if (kept) begin
                        if (!full_before || mpop) q.push_back(fir_data);
                        else begin
                            movf = 1;
                            if (mdrops < 65535) mdrops++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (m_valid !== 0 || m_data !== 0 || level !== 0 || overflow !== 0 || drop_cnt !== 0) begin
            errors++;
            $display("FAIL reset: got v=%0b d=%0h l=%0d o=%0b c=%0d expected all zero",
                     m_valid, m_data, level, overflow, drop_cnt);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        int vals[5] = '{100, -200, 300, -400, 500};
        decim = 8'd1; m_ready = 1;
        for (int i = 0; i < 5; i++) begin
            fir_data = 16'(vals[i]); fir_ready = 1;
            tick();
            checks++;
            if (m_valid !== 1 || m_data !== 16'(vals[i]) || level !== 4'd1) begin
                errors++;
                $display("FAIL basic_latency: got v=%0b d=%0h l=%0d expected v=1 d=%0h l=1",
                         m_valid, m_data, level, 16'(vals[i]));
            end
        end
        fir_ready = 0;
        tick();
        checks++;
        if (m_valid !== 0 || overflow !== 0) begin
            errors++; $display("FAIL basic_end: got v=%0b o=%0b expected 0 0", m_valid, overflow);
        end
    endtask

    task automatic test_decim();
        int p0;
        decim = 8'd3; m_ready = 1;
        p0 = pops;
        for (int i = 1; i <= 9; i++) begin
            fir_data = 16'(i); fir_ready = 1;
            tick();
            checks++;
            if (level > 4'd1) begin
                errors++; $display("FAIL decim_level: got %0d expected <=1", level);
            end
        end
        fir_ready = 0;
        tick(); tick();
        checks++;
        if (pops - p0 != 3 || last_pop !== 16'd7) begin
            errors++; $display("FAIL decim3: got pops=%0d last=%0d expected 3 7", pops - p0, last_pop);
        end
        // Lowering the factor below the running count must wrap on the next strobe.
        p0 = pops;
        decim = 8'd5;
        for (int i = 50; i <= 52; i++) begin
            fir_data = 16'(i); fir_ready = 1; tick();
        end
        decim = 8'd2;
        for (int i = 53; i <= 54; i++) begin
            fir_data = 16'(i); fir_ready = 1; tick();
        end
        fir_ready = 0;
        tick(); tick();
        checks++;
        if (pops - p0 != 2 || last_pop !== 16'd54) begin
            errors++; $display("FAIL decim_change: got pops=%0d last=%0d expected 2 54", pops - p0, last_pop);
        end
    endtask

    task automatic test_overflow();
        int p0;
        clear = 1; tick(); clear = 0;
        decim = 8'd1; m_ready = 0;
        for (int i = 10; i <= 21; i++) begin
            fir_data = 16'(i); fir_ready = 1; tick();
        end
        fir_ready = 0;
        tick();
        checks++;
        if (level !== 4'd8 || overflow !== 1 || drop_cnt !== 16'd4 || m_data !== 16'd10) begin
            errors++;
            $display("FAIL overflow: got l=%0d o=%0b c=%0d d=%0d expected 8 1 4 10",
                     level, overflow, drop_cnt, m_data);
        end
        p0 = pops;
        m_ready = 1;
        for (int i = 0; i < 20 && m_valid; i++) tick();
        m_ready = 0;
        checks++;
        if (m_valid !== 0 || pops - p0 != 8 || last_pop !== 16'd17) begin
            errors++;
            $display("FAIL overflow_drain: got v=%0b pops=%0d last=%0d expected 0 8 17",
                     m_valid, pops - p0, last_pop);
        end
    endtask

    task automatic test_full_pop();
        int p0;
        m_ready = 0;
        for (int i = 30; i <= 37; i++) begin
            fir_data = 16'(i); fir_ready = 1; tick();
        end
        fir_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_valid !== 1 || m_data !== 16'd30) begin
                errors++; $display("FAIL stall_stable: got v=%0b d=%0d expected 1 30", m_valid, m_data);
            end
        end
        p0 = pops;
        m_ready = 1; fir_data = 16'h7FFF; fir_ready = 1;
        tick();
        m_ready = 0; fir_ready = 0;
        checks++;
        if (level !== 4'd8 || drop_cnt !== 16'd4 || m_data !== 16'd31) begin
            errors++;
            $display("FAIL full_pop: got l=%0d c=%0d d=%0d expected 8 4 31", level, drop_cnt, m_data);
        end
        m_ready = 1;
        for (int i = 0; i < 20 && m_valid; i++) tick();
        m_ready = 0;
        checks++;
        if (m_valid !== 0 || pops - p0 != 9 || last_pop !== 16'h7FFF) begin
            errors++;
            $display("FAIL full_pop_drain: got v=%0b pops=%0d last=%0h expected 0 9 7fff",
                     m_valid, pops - p0, last_pop);
        end
    endtask

    task automatic test_clear();
        m_ready = 0;
        for (int i = 40; i <= 42; i++) begin
            fir_data = 16'(i); fir_ready = 1; tick();
        end
        clear = 1; fir_data = 16'd99; fir_ready = 1; m_ready = 1;
        tick();
        clear = 0; fir_ready = 0; m_ready = 0;
        checks++;
        if (level !== 0 || m_valid !== 0 || overflow !== 0 || drop_cnt !== 0) begin
            errors++;
            $display("FAIL clear: got l=%0d v=%0b o=%0b c=%0d expected all zero",
                     level, m_valid, overflow, drop_cnt);
        end
        tick();
        checks++;
        if (level !== 0) begin
            errors++; $display("FAIL clear_nostore: got l=%0d expected 0", level);
        end
    endtask

    task automatic test_async_reset();
        m_ready = 0; decim = 8'd1;
        for (int i = 70; i <= 74; i++) begin
            fir_data = 16'(i); fir_ready = 1; tick();
        end
        fir_ready = 0;
        checks++;
        if (level !== 4'd5 || m_valid !== 1) begin
            errors++; $display("FAIL pre_reset: got l=%0d v=%0b expected 5 1", level, m_valid);
        end
        @(posedge clk);
        #3 rst = 1;
        #1;
        checks++;
        if (m_valid !== 0 || m_data !== 0 || level !== 0 || overflow !== 0 || drop_cnt !== 0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b d=%0h l=%0d o=%0b c=%0d expected all zero",
                     m_valid, m_data, level, overflow, drop_cnt);
        end
        tick();
        rst = 0;
        decim = 8'd0; m_ready = 1; fir_data = 16'h8001; fir_ready = 1;
        tick();
        fir_ready = 0;
        checks++;
        if (m_valid !== 1 || m_data !== 16'h8001) begin
            errors++; $display("FAIL post_reset: got v=%0b d=%0h expected 1 8001", m_valid, m_data);
        end
        tick();
        checks++;
        if (m_valid !== 0 || last_pop !== 16'h8001) begin
            errors++; $display("FAIL post_reset_pop: got v=%0b last=%0h expected 0 8001", m_valid, last_pop);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_overflow();
        test_full_pop();
        test_clear();
        test_async_reset();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_out_sink.md
Name: fir_out_sink

Overview:
- Receiving end of the FIR filter output interface: captures each 16-bit signed sample presented with the one-cycle `fir_ready` strobe.
- Optionally decimates the sample stream by a runtime factor and buffers kept samples in a small first-word-fall-through FIFO.
- Delivers buffered samples to downstream logic (DAC formatter, UART framer) over a valid/ready handshake.
- Reports overflow and counts dropped samples, because the FIR side has no backpressure.

Parameters:
- DATA_W, 16, sample width; matches the FIR output width.
- DEPTH, 8, FIFO depth in samples; power of two, minimum 2.
- DECIM_W, 8, width of the decimation factor input.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fir_data  in  DATA_W  signed sample from the FIR; sampled only when fir_ready=1.
- fir_ready  in  1  sample strobe; one sample per high cycle; may stay high on consecutive cycles.
- decim  in  DECIM_W  decimation factor; 0 and 1 both mean keep every sample.
- clear  in  1  synchronous flush/clear pulse.
- m_data  out  DATA_W  FIFO head sample.
- m_valid  out  1  head sample valid.
- m_ready  in  1  downstream accept.
- level  out  log2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: at least one kept sample was dropped.
- drop_cnt  out  16  saturating count of dropped samples.

Behaviour:
- Reset (rst=1, asynchronous): FIFO empty, read and write pointers 0, decimation counter 0.
  - Outputs: m_valid=0, m_data=0, level=0, overflow=0, drop_cnt=0.
  - Reset asserted mid-transfer discards all buffered data; no partial state survives.
- Decimation counter dcnt (DECIM_W bits):
  - Advances only on cycles with fir_ready=1.
  - A sample is "kept" when dcnt==0.
  - dcnt increments; when dcnt==decim-1 it wraps to 0. With decim<=1, dcnt stays 0 and every sample is kept.
  - If decim changes so that dcnt>=decim-1, the next strobe wraps dcnt to 0. No hang, no stuck state.
  - decim is sampled every strobe; it is not latched.
- Push: a kept sample is written on the strobe cycle.
  - It appears at m_data with m_valid=1 on the next cycle when the FIFO was empty (latency 1 cycle).
- Pop: occurs when m_valid && m_ready; the FIFO head advances on that edge.
  - m_data and m_valid are stable while m_valid=1 and m_ready=0.
  - m_data holds its last value when empty; consumers must ignore it then.
- Full (level==DEPTH) with a kept sample and no pop in the same cycle:
  - The sample is dropped.
  - overflow is set (sticky).
  - drop_cnt increments and saturates at 16'hFFFF.
- Full with a kept sample and a pop in the same cycle: the push is accepted and level stays DEPTH. No drop.
- Empty with a kept sample and m_ready=1: no bypass. The sample is written; m_valid rises next cycle.
- Simultaneous push and pop when not full/empty: level unchanged; pointers wrap modulo DEPTH.
- level: registered; updated the cycle after each push/pop.
- clear=1 (synchronous, highest priority after rst):
  - Empties the FIFO and zeroes dcnt, overflow and drop_cnt.
  - Any push or pop in the same cycle is ignored; m_valid=0 next cycle.
- Arithmetic: samples pass through unmodified; sign is preserved bit-exact. No rounding or scaling in this block.

Test Plan:
- Reset, decim=1, five strobes with fir_data 100, -200, 300, -400, 500, m_ready=1 -> m_data shows the same five values in order, each 1 cycle after its strobe; level peaks at 1; overflow=0.
- decim=3, nine consecutive strobes with values 1..9, m_ready=1 -> only 1, 4, 7 emitted; dcnt wraps correctly; level never exceeds 1.
- DEPTH=8, decim=1, m_ready=0, twelve strobes of 10..21 -> level=8, overflow=1, drop_cnt=4; then m_ready=1 -> emits 10..17 only, m_valid falls after the 8th pop.
- FIFO full, strobe with value 0x7FFF on the same cycle as a pop -> no drop (drop_cnt unchanged), level stays 8, 0x7FFF emitted last; m_data held stable across m_ready=0 stalls.
- After an overflow, pulse clear on a cycle with a strobe and m_ready=1 -> next cycle level=0, m_valid=0, overflow=0, drop_cnt=0; the strobed sample is not stored.
- Assert rst for 1 cycle while level=5 and m_valid=1 -> all outputs 0 immediately (asynchronously); first strobe after release emits normally at 1-cycle latency.
